// File: rtl/gcm_tagmask_mc_if.sv
// Shared-AES request/response bus used by the multi-channel tag-mask engine.
// The master side presents J0 blocks and collects channel-tagged results.
interface gcm_tagmask_mc_if #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
);
  logic           req;
  logic [CHW-1:0] req_ch;
  logic [127:0]   req_block;
  logic           ack;
  logic           rsp_valid;
  logic [CHW-1:0] rsp_ch;
  logic [127:0]   rsp_data;

  modport master (
    output req, req_ch, req_block,
    input  ack, rsp_valid, rsp_ch, rsp_data
  );

  modport slave (
    input  req, req_ch, req_block,
    output ack, rsp_valid, rsp_ch, rsp_data
  );
endinterface

// File: rtl/gcm_tagmask_mc.sv
// Multi-channel GCM tag-mask engine: each channel obtains E(K, J0) from one
// shared AES via a round-robin arbiter and keeps the result as its mask.
module gcm_tagmask_mc #(
  parameter int NCH        = 4,
  parameter int TMO_CYCLES = 255,
  parameter int CHW        = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*96-1:0]  iv_in,
  input  logic [NCH-1:0]     iv_we,
  input  logic [NCH-1:0]     start,
  gcm_tagmask_mc_if.master   aes,
  output logic [NCH*128-1:0] mask,
  output logic [NCH-1:0]     mask_valid,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     timeout_err,
  output logic               stray_rsp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // The timeout fires on the cycle the counter would step onto TMO_CYCLES-1,
  // so the pulse lands exactly TMO_CYCLES cycles after the grant.
  localparam int CNTW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES - 1) : 1;
  localparam logic [CNTW-1:0] TMO_FIRE = CNTW'((TMO_CYCLES >= 2) ? (TMO_CYCLES - 2) : 0);
  localparam logic TMO_EN = (TMO_CYCLES != 0);

  state_e         state_r [NCH];
  logic [95:0]    iv_r    [NCH];
  logic [127:0]   mask_r  [NCH];
  logic [CNTW-1:0] cnt_r  [NCH];
  logic [CHW-1:0] rr_ptr_r;
  logic           lock_r;
  logic [CHW-1:0] lock_ch_r;
  logic [NCH-1:0] busy_r;
  logic [NCH-1:0] mask_valid_r;
  logic [NCH-1:0] timeout_err_r;
  logic           stray_r;

  logic [NCH-1:0] pend_s;
  logic [NCH-1:0] rsp_hit_s;
  logic [NCH-1:0] tmo_hit_s;
  logic [CHW-1:0] idx_s;
  logic [CHW-1:0] pick_s;
  logic [CHW-1:0] req_ch_s;
  logic           req_s;
  logic           gnt_s;

  // Arbitration: lowest-offset pending channel from rr_ptr, held while un-acked.
  always_comb begin
    pend_s = '0;
    idx_s  = '0;
    pick_s = '0;
    for (int c = 0; c < NCH; c++) begin
      pend_s[c] = (state_r[c] == ST_PEND);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      idx_s  = CHW'((int'(rr_ptr_r) + i) % NCH);
      pick_s = pend_s[idx_s] ? idx_s : pick_s;
    end
    req_s    = |pend_s;
    req_ch_s = lock_r ? lock_ch_r : pick_s;
    gnt_s    = req_s && aes.ack;
  end

  // Per-channel response match and timeout detection.
  always_comb begin
    rsp_hit_s = '0;
    tmo_hit_s = '0;
    for (int c = 0; c < NCH; c++) begin
      rsp_hit_s[c] = aes.rsp_valid && (aes.rsp_ch == CHW'(c)) && (state_r[c] == ST_WAIT);
      tmo_hit_s[c] = TMO_EN && (state_r[c] == ST_WAIT) && (cnt_r[c] == TMO_FIRE);
    end
  end

  // Channel FSMs, IV/mask storage, arbiter pointer and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        state_r[c] <= ST_IDLE;
        iv_r[c]    <= '0;
        mask_r[c]  <= '0;
        cnt_r[c]   <= '0;
      end
      rr_ptr_r      <= '0;
      lock_r        <= 1'b0;
      lock_ch_r     <= '0;
      busy_r        <= '0;
      mask_valid_r  <= '0;
      timeout_err_r <= '0;
      stray_r       <= 1'b0;
    end else begin
      mask_valid_r  <= '0;
      timeout_err_r <= '0;
      stray_r       <= aes.rsp_valid && !(|rsp_hit_s);
      lock_r        <= req_s && !aes.ack;
      lock_ch_r     <= req_ch_s;
      if (gnt_s) begin
        rr_ptr_r <= CHW'((int'(req_ch_s) + 1) % NCH);
      end
      for (int c = 0; c < NCH; c++) begin
        case (state_r[c])
          ST_IDLE: begin
            if (iv_we[c]) begin
              iv_r[c] <= iv_in[c*96 +: 96];
            end
            if (start[c]) begin
              state_r[c] <= ST_PEND;
              busy_r[c]  <= 1'b1;
            end
          end
          ST_PEND: begin
            if (gnt_s && (req_ch_s == CHW'(c))) begin
              state_r[c] <= ST_WAIT;
              cnt_r[c]   <= '0;
            end
          end
          ST_WAIT: begin
            if (rsp_hit_s[c]) begin
              mask_r[c]       <= aes.rsp_data;
              mask_valid_r[c] <= 1'b1;
              state_r[c]      <= ST_IDLE;
              busy_r[c]       <= 1'b0;
            end else if (tmo_hit_s[c]) begin
              timeout_err_r[c] <= 1'b1;
              state_r[c]       <= ST_IDLE;
              busy_r[c]        <= 1'b0;
            end else if (TMO_EN) begin
              cnt_r[c] <= cnt_r[c] + CNTW'(1);
            end
          end
          default: begin
            state_r[c] <= ST_IDLE;
            busy_r[c]  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output wiring and mask flattening.
  always_comb begin
    mask = '0;
    for (int c = 0; c < NCH; c++) begin
      mask[c*128 +: 128] = mask_r[c];
    end
    aes.req       = req_s;
    aes.req_ch    = req_ch_s;
    aes.req_block = {iv_r[req_ch_s], 32'h0000_0001};
    mask_valid    = mask_valid_r;
    busy          = busy_r;
    timeout_err   = timeout_err_r;
    stray_rsp     = stray_r;
  end

endmodule

// File: tb/tb_gcm_tagmask_mc.sv
// Bench for gcm_tagmask_mc: a per-cycle behavioural model checked on every
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_gcm_tagmask_mc;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TMO = 8;
  localparam int S_IDLE = 0;
  localparam int S_PEND = 1;
  localparam int S_WAIT = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH*96-1:0]  iv_in;
  logic [NCH-1:0]     iv_we;
  logic [NCH-1:0]     start;
  logic [NCH*128-1:0] mask;
  logic [NCH-1:0]     mask_valid;
  logic [NCH-1:0]     busy;
  logic [NCH-1:0]     timeout_err;
  logic               stray_rsp;

  int vectors = 0;
  int fails   = 0;

  gcm_tagmask_mc_if #(.NCH(NCH)) aes ();

  gcm_tagmask_mc #(.NCH(NCH), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .iv_in(iv_in), .iv_we(iv_we), .start(start),
    .aes(aes), .mask(mask), .mask_valid(mask_valid), .busy(busy),
    .timeout_err(timeout_err), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_st     [NCH];
  logic [95:0]  m_iv     [NCH];
  logic [127:0] m_mask   [NCH];
  int           m_ack_at [NCH];
  int           m_rr;
  int           m_held;
  int           cyc = 0;
  logic [NCH-1:0] m_mv;
  logic [NCH-1:0] m_to;
  logic           m_stray;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = S_IDLE; m_iv[c] = '0; m_mask[c] = '0; m_ack_at[c] = 0;
    end
    m_rr = 0; m_held = -1; m_mv = '0; m_to = '0; m_stray = 1'b0;
  endtask

  function automatic int m_pick();
    if (m_held >= 0) return m_held;
    for (int i = 0; i < NCH; i++)
      if (m_st[(m_rr + i) % NCH] == S_PEND) return (m_rr + i) % NCH;
    return -1;
  endfunction

  task automatic m_compare();
    int p;
    logic [NCH-1:0] eb;
    p = m_pick();
    for (int c = 0; c < NCH; c++) eb[c] = (m_st[c] != S_IDLE);
    check("req", 128'(aes.req), 128'(p >= 0));
    if (p >= 0) begin
      check("req_ch", 128'(aes.req_ch), 128'(p));
      check("req_block", aes.req_block, {m_iv[p], 32'h0000_0001});
    end
    check("busy", 128'(busy), 128'(eb));
    check("mask_valid", 128'(mask_valid), 128'(m_mv));
    check("timeout_err", 128'(timeout_err), 128'(m_to));
    check("stray_rsp", 128'(stray_rsp), 128'(m_stray));
    for (int c = 0; c < NCH; c++) check("mask", mask[c*128 +: 128], m_mask[c]);
  endtask

  task automatic m_step();
    int p;
    int old_st [NCH];
    int rc;
    p = m_pick();
    for (int c = 0; c < NCH; c++) old_st[c] = m_st[c];
    m_mv = '0; m_to = '0; m_stray = 1'b0;
    rc = int'(aes.rsp_ch);
    if (aes.rsp_valid) begin
      if (rc < NCH && old_st[rc] == S_WAIT) begin
        m_mask[rc] = aes.rsp_data; m_mv[rc] = 1'b1; m_st[rc] = S_IDLE;
      end else begin
        m_stray = 1'b1;
      end
    end
    // a timeout is seen exactly TMO cycles after the grant
    for (int c = 0; c < NCH; c++)
      if (old_st[c] == S_WAIT && m_st[c] == S_WAIT && cyc + 1 == m_ack_at[c] + TMO) begin
        m_to[c] = 1'b1; m_st[c] = S_IDLE;
      end
    if (p >= 0 && aes.ack) begin
      m_st[p] = S_WAIT; m_ack_at[p] = cyc; m_rr = (p + 1) % NCH; m_held = -1;
    end else if (p >= 0) begin
      m_held = p;
    end
    for (int c = 0; c < NCH; c++)
      if (old_st[c] == S_IDLE) begin
        if (iv_we[c]) m_iv[c] = iv_in[c*96 +: 96];
        if (start[c]) m_st[c] = S_PEND;
      end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      m_compare();
      if (rst_n) m_step();
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] dat [NCH];
  logic [95:0]  ivx;
  logic [95:0]  ivy;
  int           wq [$];

  task automatic clr();
    iv_we = '0; start = '0;
    aes.ack = 1'b0; aes.rsp_valid = 1'b0; aes.rsp_ch = '0; aes.rsp_data = '0;
  endtask

  task automatic next();
    @(posedge clk); #1; clr();
  endtask

  task automatic rsp_and_check(input int ch, input logic [127:0] d);
    aes.rsp_valid = 1'b1; aes.rsp_ch = CHW'(ch); aes.rsp_data = d;
    next();
    check("rsp_mv", 128'(mask_valid), 128'(4'b0001 << ch));
    check("rsp_mask", mask[ch*128 +: 128], d);
  endtask

  initial begin
    rst_n = 1'b0; iv_in = '0; clr();
    for (int i = 0; i < NCH; i++) dat[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 128'(aes.req), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_mask", mask[127:0], 128'(0));
    rst_n = 1'b1;
    next();

    // arbitration: all four start together, ack held high
    start = 4'hF;
    next();
    for (int i = 0; i < NCH; i++) begin
      check("arb_order", 128'(aes.req_ch), 128'(i));
      aes.ack = 1'b1;
      next();
    end
    // out-of-order completion
    rsp_and_check(0, dat[0]);
    rsp_and_check(2, dat[2]);
    rsp_and_check(1, dat[1]);
    rsp_and_check(3, dat[3]);

    // rr pointer after a grant of channel 0 favours channel 1
    start[0] = 1'b1; next();
    aes.ack = 1'b1; next();
    rsp_and_check(0, dat[1]);
    start = 4'b0011; next();
    check("rr_first", 128'(aes.req_ch), 128'(1));
    aes.ack = 1'b1; next();
    check("rr_second", 128'(aes.req_ch), 128'(0));
    aes.ack = 1'b1; next();
    rsp_and_check(1, dat[2]);
    rsp_and_check(0, dat[0]);

    // held request is not preempted; then both channels time out
    start[3] = 1'b1; next();
    check("hold_pick", 128'(aes.req_ch), 128'(3));
    start[2] = 1'b1; next();
    for (int i = 0; i < 5; i++) begin
      check("hold_req_ch", 128'(aes.req_ch), 128'(3));
      next();
    end
    aes.ack = 1'b1; next();
    check("after_hold", 128'(aes.req_ch), 128'(2));
    aes.ack = 1'b1; next();
    for (int k = 2; k <= 10; k++) begin
      check("timeout_pulse", 128'(timeout_err), 128'((k == 8) ? 4'b1000 : (k == 9) ? 4'b0100 : 4'b0000));
      next();
    end
    aes.rsp_valid = 1'b1; aes.rsp_ch = 2'd3; aes.rsp_data = '1;
    next();
    check("late_stray", 128'(stray_rsp), 128'(1));
    check("tmo_mask_kept", mask[3*128 +: 128], dat[3]);

    // single channel latency
    iv_in[95:0] = 96'hCAFEBABE_00000000_12345678; iv_we[0] = 1'b1; start[0] = 1'b1;
    next();
    check("single_busy", 128'(busy[0]), 128'(1));
    check("single_block", aes.req_block, 128'hCAFEBABE_00000000_12345678_00000001);
    aes.ack = 1'b1; next();
    check("single_noreq", 128'(aes.req), 128'(0));
    next();
    aes.rsp_valid = 1'b1; aes.rsp_ch = 2'd0; aes.rsp_data = {16{8'hA5}};
    next();
    check("single_mv", 128'(mask_valid), 128'(4'b0001));
    check("single_mask", mask[127:0], {16{8'hA5}});
    check("single_busy_fall", 128'(busy[0]), 128'(0));
    next();
    check("single_mv_once", 128'(mask_valid), 128'(0));

    // ignored events on a busy channel, then a response for an idle channel
    ivx = {$urandom, $urandom, $urandom}; ivy = ~ivx;
    iv_in[96 +: 96] = ivx; iv_we[1] = 1'b1; start[1] = 1'b1; next();
    iv_in[96 +: 96] = ivy; iv_we[1] = 1'b1; start[1] = 1'b1; next();
    check("ign_block", aes.req_block, {ivx, 32'h0000_0001});
    aes.ack = 1'b1; next();
    iv_we[1] = 1'b1; start[1] = 1'b1; next();
    check("ign_noreq", 128'(aes.req), 128'(0));
    aes.rsp_valid = 1'b1; aes.rsp_ch = 2'd3; aes.rsp_data = '1; next();
    check("ign_stray", 128'(stray_rsp), 128'(1));
    aes.rsp_valid = 1'b1; aes.rsp_ch = 2'd1; aes.rsp_data = dat[3]; next();
    check("ign_stray_once", 128'(stray_rsp), 128'(0));
    start[1] = 1'b1; next();
    check("ign_iv_frozen", aes.req_block, {ivx, 32'h0000_0001});
    aes.ack = 1'b1; next();
    rsp_and_check(1, dat[0]);

    // asynchronous reset with two channels in WAIT
    start = 4'b0110; next();
    aes.ack = 1'b1; next();
    aes.ack = 1'b1; next();
    rst_n = 1'b0; #1;
    check("arst_req", 128'(aes.req), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_mask1", mask[128 +: 128], 128'(0));
    check("arst_pulses", 128'({mask_valid, timeout_err, stray_rsp}), 128'(0));
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      check("post_rst_req", 128'(aes.req), 128'(0));
    end
    aes.rsp_valid = 1'b1; aes.rsp_ch = 2'd1; aes.rsp_data = dat[1]; next();
    check("post_rst_stray", 128'(stray_rsp), 128'(1));

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int w = 0; w < NCH * 3; w++) iv_in[w*32 +: 32] = $urandom;
      iv_we   = 4'($urandom) & 4'($urandom);
      start   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      aes.ack = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 2) == 0) begin
        wq.delete();
        for (int c = 0; c < NCH; c++) if (m_st[c] == S_WAIT) wq.push_back(c);
        aes.rsp_valid = 1'b1;
        if (wq.size() > 0 && $urandom_range(0, 9) < 8)
          aes.rsp_ch = CHW'(wq[$urandom_range(0, wq.size() - 1)]);
        else
          aes.rsp_ch = CHW'($urandom_range(0, NCH - 1));
        aes.rsp_data = {$urandom, $urandom, $urandom, $urandom};
      end
      next();
    end
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
